// File: rtl/servo_slew_limiter_if.sv
// Command and position bus between the SPI command latch, the slew limiter and the PWM stage.
interface servo_slew_limiter_if;
    logic       cmd_valid;
    logic [7:0] cmd_x;
    logic [7:0] cmd_y;
    logic       cmd_ready;
    logic       frame_tick;
    logic [7:0] pos_x;
    logic [7:0] pos_y;
    logic       pos_valid;
    logic       moving;
    logic       wd_trip;

    modport master (
        output cmd_valid, cmd_x, cmd_y,
        input  cmd_ready, frame_tick, pos_x, pos_y, pos_valid, moving, wd_trip
    );

    modport slave (
        input  cmd_valid, cmd_x, cmd_y,
        output cmd_ready, frame_tick, pos_x, pos_y, pos_valid, moving, wd_trip
    );
endinterface

// File: rtl/servo_slew_limiter.sv
// Once-per-frame slew limiter for X/Y servo angles; outputs never move more than STEP LSB per frame.
// Optional idle watchdog that parks both axes at HOME: define SLEW_WATCHDOG_EN.
module servo_slew_limiter #(
    parameter int unsigned CLK_HZ    = 48_000_000,
    parameter int unsigned FRAME_HZ  = 400,
    parameter int unsigned STEP      = 2,
    parameter logic [7:0]  HOME      = 8'd128,
    parameter int unsigned WD_FRAMES = 200
) (
    input logic                 CLK,
    input logic                 rst,
    servo_slew_limiter_if.slave bus
);

    localparam int unsigned FRAME_LEN = CLK_HZ / FRAME_HZ;
    localparam int unsigned CNT_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
    localparam logic signed [8:0] STEP_S  = 9'(STEP);
    localparam logic [7:0]        STEP_U  = 8'(STEP);

    generate
        if (FRAME_LEN < 4) begin : g_bad_frame_len
            $error("servo_slew_limiter: FRAME_LEN must be >= 4");
        end
        if (STEP < 1 || STEP > 255) begin : g_bad_step
            $error("servo_slew_limiter: STEP must be 1..255");
        end
        if (WD_FRAMES < 1) begin : g_bad_wd
            $error("servo_slew_limiter: WD_FRAMES must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, STEP_X, STEP_Y, PUBLISH} state_t;

    // Moves pos toward tgt by at most STEP; the 9-bit difference keeps 0 and 255 exact.
    function automatic logic [7:0] slew(input logic [7:0] pos, input logic [7:0] tgt);
        logic signed [8:0] d;
        d = signed'({1'b0, tgt}) - signed'({1'b0, pos});
        if (d <= STEP_S && d >= -STEP_S) slew = tgt;
        else if (d > 9'sd0)              slew = pos + STEP_U;
        else                             slew = pos - STEP_U;
    endfunction

    logic [CNT_W-1:0] frame_cnt;
    logic             tick;
    state_t           state;
    logic [7:0]       pos_x, pos_y, tgt_x, tgt_y;
    logic             pos_valid_q, moving_q;
    logic             xfer;

    assign tick          = (frame_cnt == LAST_CNT);
    assign bus.cmd_ready = (state == IDLE) & ~rst;
    assign xfer          = bus.cmd_valid & bus.cmd_ready;

    always_ff @(posedge CLK) begin
        if (rst || tick) frame_cnt <= '0;
        else             frame_cnt <= frame_cnt + 1'b1;
    end

`ifdef SLEW_WATCHDOG_EN
    localparam int unsigned WD_W = (WD_FRAMES > 1) ? $clog2(WD_FRAMES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_FRAMES - 1);
    logic [WD_W-1:0] idle_cnt;
    logic            wd_trip_q;
`endif

    always_ff @(posedge CLK) begin
        if (rst) begin
            state       <= IDLE;
            pos_x       <= HOME;
            pos_y       <= HOME;
            tgt_x       <= HOME;
            tgt_y       <= HOME;
            pos_valid_q <= 1'b0;
            moving_q    <= 1'b0;
`ifdef SLEW_WATCHDOG_EN
            idle_cnt    <= '0;
            wd_trip_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking updates let PUBLISH compare against this cycle's pos/tgt,
            // and a same-cycle command load wins over nothing else in flight.
            pos_valid_q <= 1'b0;
            case (state)
                IDLE:    if (tick) state <= STEP_X;
                STEP_X:  begin
                    pos_x <= slew(pos_x, tgt_x);
                    state <= STEP_Y;
                end
                STEP_Y:  begin
                    pos_y       <= slew(pos_y, tgt_y);
                    pos_valid_q <= 1'b1;
                    state       <= PUBLISH;
                end
                PUBLISH: begin
                    moving_q <= (pos_x != tgt_x) || (pos_y != tgt_y);
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (xfer) begin
                tgt_x    <= bus.cmd_x;
                tgt_y    <= bus.cmd_y;
                moving_q <= (pos_x != bus.cmd_x) || (pos_y != bus.cmd_y);
            end

`ifdef SLEW_WATCHDOG_EN
            // A command always clears the watchdog; otherwise count frames until parking.
            if (xfer) begin
                idle_cnt  <= '0;
                wd_trip_q <= 1'b0;
            end else if (tick && !wd_trip_q) begin
                if (idle_cnt == WD_LAST) begin
                    tgt_x     <= HOME;
                    tgt_y     <= HOME;
                    wd_trip_q <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
`endif
        end
    end

    assign bus.frame_tick = tick;
    assign bus.pos_x      = pos_x;
    assign bus.pos_y      = pos_y;
    assign bus.pos_valid  = pos_valid_q;
    assign bus.moving     = moving_q;
`ifdef SLEW_WATCHDOG_EN
    assign bus.wd_trip    = wd_trip_q;
`else
    assign bus.wd_trip    = 1'b0;
`endif

endmodule
